// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] BP_NOP0 = 2'b00;
  localparam logic [1:0] BP_ADD  = 2'b01;
  localparam logic [1:0] BP_SUB  = 2'b10;
  localparam logic [1:0] BP_NOP1 = 2'b11;

  localparam int unsigned UNIT_W = 4;

endpackage

// File: rtl/booth_mul_ctrl_addsub.sv
// Shared 4-bit add/subtract unit of the lab ALU: z = A + B (M=0) or A - B (M=1).
module AdderSubtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] z,
  output logic       C,
  output logic       V
);

  logic [3:0] b_eff_s;
  logic [4:0] sum_s;

  // Subtraction is A + ~B + 1; the mode bit doubles as carry-in.
  assign b_eff_s = B ^ {4{M}};
  assign sum_s   = {1'b0, A} + {1'b0, b_eff_s} + {4'b0000, M};
  assign z       = sum_s[3:0];
  assign C       = sum_s[4];
  assign V       = (A[3] == b_eff_s[3]) && (sum_s[3] != A[3]);

endmodule

// File: rtl/booth_mul_ctrl.sv
// Sequential signed 4x4 radix-2 Booth multiplier built around one shared add/subtract unit.
module booth_mul_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != 4) begin : g_bad_width
    $error("booth_mul_ctrl: WIDTH must equal 4 (width of the shared add/subtract unit)");
  end

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   q_r;
  logic               qm1_r;
  logic [WIDTH-1:0]   m_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] product_r;
  logic               busy_r;
  logic               done_r;

  logic [1:0]         pair_s;
  logic               sub_mode_s;
  logic [WIDTH-1:0]   z_s;
  logic               v_s;
  logic               addsub_c_unused_s;
  logic [WIDTH-1:0]   r_s;
  logic               sign_in_s;
  logic [WIDTH-1:0]   a_next_s;
  logic [WIDTH-1:0]   q_next_s;
  logic               qm1_next_s;

  assign pair_s     = {q_r[0], qm1_r};
  assign sub_mode_s = (pair_s == BP_SUB);

  AdderSubtractor u_addsub (
    .A (a_r),
    .B (m_r),
    .M (sub_mode_s),
    .z (z_s),
    .C (addsub_c_unused_s),
    .V (v_s)
  );

  // Booth step: select unit result or old A, then arithmetic shift of {A,Q,Q-1}.
  always_comb begin
    r_s       = a_r;
    sign_in_s = a_r[WIDTH-1];
    case (pair_s)
      BP_ADD, BP_SUB: begin
        r_s       = z_s;
        sign_in_s = z_s[WIDTH-1] ^ v_s;
      end
      BP_NOP0, BP_NOP1: begin
        r_s       = a_r;
        sign_in_s = a_r[WIDTH-1];
      end
      default: begin
        r_s       = a_r;
        sign_in_s = a_r[WIDTH-1];
      end
    endcase
    a_next_s   = {sign_in_s, r_s[WIDTH-1:1]};
    q_next_s   = {r_s[0], q_r[WIDTH-1:1]};
    qm1_next_s = q_r[0];
  end

  // Controller FSM with all datapath state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      a_r       <= '0;
      q_r       <= '0;
      qm1_r     <= 1'b0;
      m_r       <= '0;
      cnt_r     <= '0;
      product_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            m_r     <= multiplicand;
            q_r     <= multiplier;
            a_r     <= '0;
            qm1_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_r   <= a_next_s;
          q_r   <= q_next_s;
          qm1_r <= qm1_next_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_STEP) begin
            product_r <= {a_next_s, q_next_s};
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: directed table, corner sequences, random and exhaustive sweeps.
module tb_booth_mul_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_total = 0;
  int n_pass  = 0;

  booth_mul_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
  } vec_t;

  // Reference: plain signed integer multiplication, truncated to 8 bits.
  function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
    logic signed [3:0] sm;
    logic signed [3:0] sq;
    int p;
    sm = m;
    sq = q;
    p  = int'(sm) * int'(sq);
    return p[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Enters and leaves at a negedge with the DUT idle; scrambles operand inputs while running.
  task automatic do_mul(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                        input string name, input bit full);
    int busy_cnt;
    int guard;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    guard    = 0;
    while (!done && guard < 12) begin
      if (busy) busy_cnt++;
      multiplicand = 4'($urandom);
      multiplier   = 4'($urandom);
      @(negedge clk);
      guard++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_product"}, 32'(product), 32'(exp));
    if (full) begin
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
      chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    @(negedge clk);
    if (full) chk({name, "_done_width"}, 32'(done), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    int done_cyc[$];
    int seen;

    tbl[0] = '{4'h3, 4'h2, 8'h06};
    tbl[1] = '{4'hD, 4'h5, 8'hF1};
    tbl[2] = '{4'h7, 4'h8, 8'hC8};
    tbl[3] = '{4'h8, 4'h8, 8'h40};
    tbl[4] = '{4'hF, 4'hF, 8'h01};
    tbl[5] = '{4'h0, 4'h8, 8'h00};
    tbl[6] = '{4'h7, 4'h7, 8'h31};
    tbl[7] = '{4'h8, 4'h7, 8'hC8};

    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = 4'h0;
    multiplier   = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'h00);

    for (int i = 0; i < 8; i++) begin
      do_mul(tbl[i].m, tbl[i].q, tbl[i].exp, $sformatf("vec%0d", i), 1'b1);
    end

    // Product holds through idle cycles.
    repeat (3) @(negedge clk);
    chk("product_hold", 32'(product), 32'h C8);

    // Start held high: back-to-back runs, one done every 6 cycles.
    multiplicand = 4'h2;
    multiplier   = 4'h3;
    start        = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(c);
        chk("held_product", 32'(product), 32'h06);
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_cyc.size()), 32'd5);
    for (int j = 1; j < done_cyc.size(); j++) begin
      chk("held_done_period", 32'(done_cyc[j] - done_cyc[j-1]), 32'd6);
    end
    repeat (8) @(negedge clk);

    // Reset during the second Booth step aborts the run.
    multiplicand = 4'h3;
    multiplier   = 4'h2;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_product", 32'(product), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    do_mul(4'hF, 4'hF, 8'h01, "after_abort", 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] rm;
      logic [3:0] rq;
      rm = 4'($urandom);
      rq = 4'($urandom);
      do_mul(rm, rq, ref_prod(rm, rq), $sformatf("rand_%0h_%0h", rm, rq), 1'b0);
    end

    for (int m = 0; m < 16; m++) begin
      for (int q = 0; q < 16; q++) begin
        do_mul(4'(m), 4'(q), ref_prod(4'(m), 4'(q)), $sformatf("sweep_%0h_%0h", m, q), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
